// File: rtl/apu_axis_pkg.sv
// Shared definitions for the APU AXI4-Stream adaptors (upstream and downstream).
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apu_axis_pkg;

    localparam int DATA_WIDTH_DEF = 128;
    localparam int TID_WIDTH_DEF  = 11;
    localparam int KEEP_WIDTH_DEF = DATA_WIDTH_DEF / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } adp_state_e;

endpackage

// File: rtl/apu_skid_fifo2.sv
// Two-entry FIFO with registered outputs; holds {TLAST, TDATA} between memory and stream.
// Latency: push at edge n is visible on vld_o/dat_o after that edge (1 cycle).
// Backpressure: pop_i is ignored when empty; the producer's credit keeps pushes within 2 entries.
// Ports: clk_i, rst_ni (sync, active-low), push_i/push_dat_i, pop_i, vld_o/dat_o (head), count_o.
module apu_skid_fifo2
    import apu_axis_pkg::*;
#(
    parameter int W = 129
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok;

    assign pop_ok = pop_i && (cnt_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = push_dat_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_ok) begin
                    head_d = push_dat_i;
                end else if (push_i) begin
                    tail_d = push_dat_i;
                    cnt_d  = 2'd2;
                end else if (pop_ok) begin
                    // Clear the head so a stale TLAST/TDATA never lingers on an idle stream.
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_dat_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign vld_o   = (cnt_q != 2'd0);
    assign dat_o   = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/multi_upstream_adp.sv
// Reads one event from NUM_PORTS buffer memories (sequential or word-interleaved) onto one AXI4-Stream.
// Latency: ready sampled at edge k, rd_en in the following cycle, first TVALID after edge k+2; 1 beat/cycle.
// Backpressure: reads are issued only while FIFO occupancy + in-flight read - accepted beat < 2.
// Ports: clk, ARESETn (sync, active-low), rd_EvTID_ready/rd_EvTID_DONE event handshake,
//        rd_en/rd_addr/rd_data per-port memory interface, TVALID/TREADY/TDATA/TSTRB/TKEEP/TLAST/TID stream.
module multi_upstream_adp
    import apu_axis_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = 16,
    parameter int INTERLEAVE = 0,
    parameter int TID_WIDTH  = TID_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  ARESETn,
    input  logic                                  rd_EvTID_ready,
    output logic                                  rd_EvTID_DONE,
    output logic [NUM_PORTS-1:0]                  rd_en,
    output logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic                                  TVALID,
    input  logic                                  TREADY,
    output logic [DATA_WIDTH-1:0]                 TDATA,
    output logic [DATA_WIDTH/8-1:0]               TSTRB,
    output logic [DATA_WIDTH/8-1:0]               TKEEP,
    output logic                                  TLAST,
    output logic [TID_WIDTH-1:0]                  TID
);

    localparam int WCW = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(NUM_PORTS + 1);

    adp_state_e state_q, state_d;
    logic [WCW-1:0] w_q, w_d;
    logic [PCW-1:0] p_q, p_d;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PCW-1:0] rd_port_q;
    logic           rd_last_q;
    logic           inflight_q;
    logic [TID_WIDTH-1:0] tid_q;

    logic                  fifo_vld;
    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH:0]   fifo_dat;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [2:0]            credit_sum;
    logic                  pop, issue, last_rd;

    assign pop     = fifo_vld & TREADY;
    assign last_rd = (w_q == WCW'(DEPTH - 1)) && (p_q == PCW'(NUM_PORTS - 1));

    // A beat leaving this cycle frees its slot for a read issued this cycle, so pop is
    // subtracted; pop implies fifo_cnt >= 1, so the sum never underflows.
    assign credit_sum = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == READ) && (credit_sum < 3'd2);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (rd_EvTID_ready) begin
                    state_d = READ;
                    w_d     = '0;
                    p_d     = '0;
                end
            end
            READ: begin
                if (issue) begin
                    if (last_rd) begin
                        state_d = DRAIN;
                    end else if (INTERLEAVE == 0) begin
                        if (w_q == WCW'(DEPTH - 1)) begin
                            w_d = '0;
                            p_d = p_q + PCW'(1);
                        end else begin
                            w_d = w_q + WCW'(1);
                        end
                    end else begin
                        if (p_q == PCW'(NUM_PORTS - 1)) begin
                            p_d = '0;
                            w_d = w_q + WCW'(1);
                        end else begin
                            p_d = p_q + PCW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!fifo_vld && !inflight_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the selected port sees its enable and the new address; others keep their last address.
    always_comb begin
        rd_en   = '0;
        addr_d  = addr_q;
        rd_addr = addr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (issue && (p_q == PCW'(i))) begin
                rd_en[i]   = 1'b1;
                addr_d[i]  = ADDR_WIDTH'(w_q);
                rd_addr[i] = ADDR_WIDTH'(w_q);
            end
        end
    end

    // Returning data is taken from the port remembered alongside the read.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_port_q == PCW'(i)) begin
                rd_word = rd_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            w_q        <= '0;
            p_q        <= '0;
            addr_q     <= '0;
            rd_port_q  <= '0;
            rd_last_q  <= 1'b0;
            inflight_q <= 1'b0;
            tid_q      <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            p_q        <= p_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            if (issue) begin
                rd_port_q <= p_q;
                rd_last_q <= last_rd;
            end
            if (state_q == DONE) begin
                tid_q <= tid_q + TID_WIDTH'(1);
            end
        end
    end

    apu_skid_fifo2 #(
        .W (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (ARESETn),
        .push_i     (inflight_q),
        .push_dat_i ({rd_last_q, rd_word}),
        .pop_i      (pop),
        .vld_o      (fifo_vld),
        .dat_o      (fifo_dat),
        .count_o    (fifo_cnt)
    );

    assign TVALID        = fifo_vld;
    assign TLAST         = fifo_dat[DATA_WIDTH];
    assign TDATA         = fifo_dat[DATA_WIDTH-1:0];
    assign TSTRB         = '1;
    assign TKEEP         = '1;
    assign TID           = tid_q;
    assign rd_EvTID_DONE = (state_q == DONE);

endmodule
